// File: rtl/axis_hdr_pkg.sv
// Shared types and keep-vector helpers for the AXI-Stream header inserter.
// Keep vectors are zero-extended to KEEP_MAX bits so one set of helpers serves every beat width.
package axis_hdr_pkg;

   localparam int KEEP_MAX = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] keep);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < KEEP_MAX; i++) c = c + 8'(keep[i]);
      return c;
   endfunction

   // Top cnt bits of an n-bit keep field.
   function automatic logic [KEEP_MAX-1:0] keep_msb(input int cnt, input int n);
      logic [KEEP_MAX-1:0] k;
      k = '0;
      for (int i = 0; i < KEEP_MAX; i++)
         if (i < n && i >= n - cnt) k[i] = 1'b1;
      return k;
   endfunction

   function automatic logic is_contig_lsb(input logic [KEEP_MAX-1:0] keep);
      return (keep & (keep + KEEP_MAX'(1))) == '0;
   endfunction

   // MSB-contiguous within n bits means the inverted field is LSB-contiguous.
   function automatic logic is_contig_msb(input logic [KEEP_MAX-1:0] keep, input int n);
      logic [KEEP_MAX-1:0] mask;
      logic [KEEP_MAX-1:0] inv;
      mask = (n >= KEEP_MAX) ? '1 : ((KEEP_MAX'(1) << n) - KEEP_MAX'(1));
      inv  = ~keep & mask;
      return (inv & (inv + KEEP_MAX'(1))) == '0;
   endfunction

endpackage

// File: rtl/axis_hdr_merge_shift.sv
// Byte realignment: combines h residue bytes with the upper N-h bytes of the incoming beat.
// Also returns the new residue, both right-justified and left-justified for a flush beat.
module axis_hdr_merge_shift
   import axis_hdr_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
   input  logic [DATA_WD-1:0]     res,
   input  logic [DATA_WD-1:0]     data_in,
   input  logic [BYTE_CNT_WD-1:0] h,
   output logic [DATA_WD-1:0]     merged,
   output logic [DATA_WD-1:0]     res_next,
   output logic [DATA_WD-1:0]     res_left
);

   localparam int SW = BYTE_CNT_WD + 3;

   logic [BYTE_CNT_WD-1:0] nh;
   logic [SW-1:0]          sh_h;
   logic [SW-1:0]          sh_nh;

   assign nh    = BYTE_CNT_WD'(DATA_BYTE_WD) - h;
   assign sh_h  = {h, 3'b000};
   assign sh_nh = {nh, 3'b000};

   // Shifts by the full width yield zero, which covers h=0 and h=N.
   assign merged   = (res << sh_nh) | (data_in >> sh_h);
   assign res_next = data_in & ~({DATA_WD{1'b1}} << sh_h);
   assign res_left = data_in << sh_nh;

endmodule

// File: rtl/axis_insert_header_v2.sv
// Prepends a 0..N byte header to each AXI-Stream packet and realigns the payload,
// flushing the last-beat residue as an extra beat when it does not fit.
//
// state  | meaning
// IDLE   | waiting for a header; payload blocked
// STREAM | merging residue with payload beats
// FLUSH  | emitting the leftover residue as the final beat
module axis_insert_header_v2
   import axis_hdr_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   input  logic                    valid_insert,
   input  logic [DATA_WD-1:0]      data_insert,
   input  logic [DATA_BYTE_WD-1:0] keep_insert,
   input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
   output logic                    ready_insert,
   output logic                    err_keep
);

   state_t                  state;
   logic [DATA_WD-1:0]      res_data;
   logic [BYTE_CNT_WD-1:0]  res_cnt;

   logic                    ld;
   logic                    hs_hdr;
   logic                    hs_pl;
   logic [BYTE_CNT_WD-1:0]  h_pop;
   logic [BYTE_CNT_WD-1:0]  k_pop;
   logic [BYTE_CNT_WD-1:0]  nh;
   logic [DATA_WD-1:0]      hdr_mask;
   logic [DATA_BYTE_WD-1:0] keep_last;
   logic [DATA_BYTE_WD-1:0] keep_flush;
   logic                    err_hdr;
   logic                    err_pl;
   logic [DATA_WD-1:0]      merged;
   logic [DATA_WD-1:0]      res_next;
   logic [DATA_WD-1:0]      res_left;

   function automatic logic [DATA_WD-1:0] expand(input logic [DATA_BYTE_WD-1:0] k);
      logic [DATA_WD-1:0] e;
      for (int i = 0; i < DATA_BYTE_WD; i++) e[i*8 +: 8] = {8{k[i]}};
      return e;
   endfunction

   assign ld           = !valid_out || ready_out;
   assign ready_insert = (state == IDLE);
   assign ready_in     = (state == STREAM) && ld;
   assign hs_hdr       = valid_insert && ready_insert;
   assign hs_pl        = valid_in && ready_in;

   assign h_pop      = BYTE_CNT_WD'(popcount(KEEP_MAX'(keep_insert)));
   assign k_pop      = BYTE_CNT_WD'(popcount(KEEP_MAX'(keep_in)));
   assign nh         = BYTE_CNT_WD'(DATA_BYTE_WD) - res_cnt;
   assign hdr_mask   = ~({DATA_WD{1'b1}} << {h_pop, 3'b000});
   assign keep_last  = DATA_BYTE_WD'(keep_msb(int'(res_cnt) + int'(k_pop), DATA_BYTE_WD));
   assign keep_flush = DATA_BYTE_WD'(keep_msb(int'(res_cnt), DATA_BYTE_WD));

   assign err_hdr = hs_hdr && (!is_contig_lsb(KEEP_MAX'(keep_insert)) || (byte_insert_cnt != h_pop));
   assign err_pl  = hs_pl && (last_in
                      ? ((keep_in == '0) || !is_contig_msb(KEEP_MAX'(keep_in), DATA_BYTE_WD))
                      : (keep_in != '1));

   axis_hdr_merge_shift #(
      .DATA_WD      (DATA_WD),
      .DATA_BYTE_WD (DATA_BYTE_WD),
      .BYTE_CNT_WD  (BYTE_CNT_WD)
   ) u_merge (
      .res      (res_data),
      .data_in  (data_in),
      .h        (res_cnt),
      .merged   (merged),
      .res_next (res_next),
      .res_left (res_left)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
         err_keep  <= 1'b0;
         data_out  <= '0;
         keep_out  <= '0;
         res_data  <= '0;
         res_cnt   <= '0;
      end else begin
         err_keep <= err_hdr || err_pl;
         if (ld) valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (hs_hdr) begin
                  res_data <= data_insert & hdr_mask;
                  res_cnt  <= h_pop;
                  state    <= STREAM;
               end
            end
            STREAM: begin
               if (hs_pl) begin
                  valid_out <= 1'b1;
                  if (last_in && (k_pop <= nh)) begin
                     data_out <= merged & expand(keep_last);
                     keep_out <= keep_last;
                     last_out <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     data_out <= merged;
                     keep_out <= '1;
                     last_out <= 1'b0;
                     if (last_in) begin
                        // Residue is stored pre-justified so FLUSH needs no shifter.
                        res_data <= res_left;
                        res_cnt  <= k_pop - nh;
                        state    <= FLUSH;
                     end else begin
                        res_data <= res_next;
                     end
                  end
               end
            end
            FLUSH: begin
               if (ld) begin
                  valid_out <= 1'b1;
                  data_out  <= res_data & expand(keep_flush);
                  keep_out  <= keep_flush;
                  last_out  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
